// File: rtl/serial_compare_ctrl_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: controller
// state encodings and the default operand width.
package serial_compare_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_compare_ctrl_comparator1_slice.sv
// One-bit comparator slice: flags a differing bit pair and says whether A wins,
// with the sense flipped for the sign bit of a two's-complement compare.
module comparator1_slice (
    input  logic a_bit,
    input  logic b_bit,
    input  logic invert,
    output logic differ,
    output logic a_wins
);

    logic w_differ;

    assign w_differ = a_bit ^ b_bit;
    assign differ   = w_differ;
    // A set sign bit means a negative value, so a 1 loses when inverted
    assign a_wins   = w_differ & (a_bit ^ invert);

endmodule

// File: rtl/serial_compare_ctrl.sv
// Sequencer that walks latched operands MSB-first through a single comparator
// slice, stopping at the first differing bit and reporting one-hot gt/lt/eq.
module serial_compare_ctrl
    import serial_compare_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             is_signed,
    output logic             ready,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic [IW-1:0]    r_idx;
    logic             r_ready;
    logic             r_done;
    logic             r_gt;
    logic             r_lt;
    logic             r_eq;

    logic w_a_bit;
    logic w_b_bit;
    logic w_invert;
    logic w_differ;
    logic w_a_wins;

    assign w_a_bit  = r_a[r_idx];
    assign w_b_bit  = r_b[r_idx];
    assign w_invert = r_signed & (r_idx == MSB_IDX);

    comparator1_slice u_slice (
        .a_bit  (w_a_bit),
        .b_bit  (w_b_bit),
        .invert (w_invert),
        .differ (w_differ),
        .a_wins (w_a_wins)
    );

    // ready and done are registered alongside the state so they change on the same edge
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_idx    <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_signed <= is_signed;
                        r_idx    <= MSB_IDX;
                        r_gt     <= 1'b0;
                        r_lt     <= 1'b0;
                        r_eq     <= 1'b0;
                        r_ready  <= 1'b0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (w_differ) begin
                        r_gt    <= w_a_wins;
                        r_lt    <= ~w_a_wins;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (r_idx == '0) begin
                        r_eq    <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign gt    = r_gt;
    assign lt    = r_lt;
    assign eq    = r_eq;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Self-checking bench for serial_compare_ctrl: directed and random compares
// checked against an arithmetic model of result flags and latency.
module tb_serial_compare_ctrl;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         is_signed;
    logic         ready;
    logic         done;
    logic         gt;
    logic         lt;
    logic         eq;

    int testCount = 0;
    int failCount = 0;

    serial_compare_ctrl #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .A         (A),
        .B         (B),
        .is_signed (is_signed),
        .ready     (ready),
        .done      (done),
        .gt        (gt),
        .lt        (lt),
        .eq        (eq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout observed=hang expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Flags are {gt,lt,eq}; n counts RUN edges from the MSB down to the first differing bit
    task automatic modelCompare(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [2:0] flags, output int n);
        logic [W-1:0] x;
        x = a ^ b;
        n = W;
        for (int i = 0; i < W; i++)
            if (x[i]) n = W - i;
        if (s) begin
            if ($signed(a) > $signed(b))      flags = 3'b100;
            else if ($signed(a) < $signed(b)) flags = 3'b010;
            else                              flags = 3'b001;
        end else begin
            if (a > b)      flags = 3'b100;
            else if (a < b) flags = 3'b010;
            else            flags = 3'b001;
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                 input bit scramble, input bit pulse);
        logic [2:0] expFlags;
        int         expN;
        int         j;
        int         readyLow;
        bit         seen;
        modelCompare(a, b, s, expFlags, expN);
        @(negedge clock);
        start = 1'b1; A = a; B = b; is_signed = s;
        @(posedge clock);
        @(negedge clock);
        start = pulse;
        checkOutput("flagsClearedOnAccept", {29'd0, gt, lt, eq}, 32'd0);
        readyLow = 0; seen = 1'b0; j = 0;
        while (!seen && j <= W + 4) begin
            if (!ready) readyLow++;
            if (done) seen = 1'b1;
            else begin
                if (scramble) begin A = W'($urandom); B = W'($urandom); end
                @(negedge clock);
                j++;
            end
        end
        checkOutput("doneSeen", {31'd0, seen}, 32'd1);
        if (seen) begin
            checkOutput("latency", j, expN);
            checkOutput("readyLowCycles", readyLow, expN + 1);
            checkOutput("flags", {29'd0, gt, lt, eq}, {29'd0, expFlags});
            @(negedge clock);
            start = 1'b0;
            checkOutput("donePulseWidth", {31'd0, done}, 32'd0);
            checkOutput("readyAfterDone", {31'd0, ready}, 32'd1);
            checkOutput("flagsHold", {29'd0, gt, lt, eq}, {29'd0, expFlags});
            @(negedge clock);
            checkOutput("stillIdle", {31'd0, ready}, 32'd1);
            checkOutput("flagsHoldIdle", {29'd0, gt, lt, eq}, {29'd0, expFlags});
        end
        start = 1'b0;
    endtask

    initial begin
        logic [2:0] f;
        int         n;
        int         prev;
        int         pulses;
        int         expPulses;
        bit         sawDone;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset = 1'b1; start = 1'b0; A = '0; B = '0; is_signed = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("resetReady", {31'd0, ready}, 32'd1);
        checkOutput("resetDone", {31'd0, done}, 32'd0);
        checkOutput("resetFlags", {29'd0, gt, lt, eq}, 32'd0);
        reset = 1'b0;

        applyStimulus(8'h02, 8'h02, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h14, 8'h0B, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h0F, 8'h26, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h33, 8'h32, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h01, 8'h02, 1'b0, 1'b1, 1'b0);

        // start held high: each compare restarts on the IDLE edge after DONE
        modelCompare(8'h80, 8'h01, 1'b0, f, n);
        expPulses = 0;
        for (int k = 0; k < 12; k++)
            if (k % (n + 2) == n) expPulses++;
        @(negedge clock);
        start = 1'b1; A = 8'h80; B = 8'h01; is_signed = 1'b0;
        prev = -1; pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (done) begin
                if (prev >= 0) checkOutput("b2bSpacing", k - prev, n + 2);
                checkOutput("b2bFlags", {29'd0, gt, lt, eq}, {29'd0, f});
                prev = k;
                pulses++;
            end
        end
        start = 1'b0;
        checkOutput("b2bPulses", pulses, expPulses);
        repeat (W + 4) @(negedge clock);

        // reset during the third RUN cycle aborts without a done pulse
        @(negedge clock);
        start = 1'b1; A = 8'h00; B = 8'h01; is_signed = 1'b0;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("abortReady", {31'd0, ready}, 32'd1);
        checkOutput("abortDone", {31'd0, done}, 32'd0);
        checkOutput("abortFlags", {29'd0, gt, lt, eq}, 32'd0);
        sawDone = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (done) sawDone = 1'b1;
        end
        checkOutput("abortNoDone", {31'd0, sawDone}, 32'd0);
        applyStimulus(8'h00, 8'h01, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            if (i % 5 == 0) rb = ra;
            else if (i % 5 == 1) rb = ra ^ W'(1 << $urandom_range(0, W - 1));
            else rb = W'($urandom);
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)), (i % 2) == 1, (i % 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/serial_compare_ctrl.md
Name: serial_compare_ctrl

Overview:
Sequencer that performs a WIDTH-bit magnitude compare one bit per cycle, MSB first, using a single 1-bit comparator slice instead of a full parallel comparator. It accepts operands through a start/ready handshake and terminates early at the first differing bit. It returns a one-hot gt/lt/eq result with a one-cycle done pulse. It serves area-constrained paths that share one slice across a compare, and acts as the cycle-level reference model for the parallel 8-bit comparator.

Parameters:
WIDTH, 8, operand width in bits (≥2)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request a compare; accepted only when ready=1
A  input  WIDTH  operand A, sampled on the accepting edge
B  input  WIDTH  operand B, sampled on the accepting edge
is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with A/B
ready  output  1  1 when state = IDLE
done  output  1  one-cycle pulse: result valid
gt  output  1  A > B
lt  output  1  A < B
eq  output  1  A == B

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- States: IDLE, RUN, DONE. State encoding is a 2-bit constant set.
- Reset: takes priority over all inputs. state→IDLE; ready=1; done=0; gt=lt=eq=0; operand/index registers cleared. Reset mid-RUN aborts the compare with no done pulse.
- IDLE: if start=1 on an edge:
  - latch A, B and is_signed; idx←WIDTH−1; clear gt/lt/eq; →RUN.
  - start=0: remain in IDLE.
- RUN, once per edge, compare bit idx of the latched operands:
  - bits differ: result = A bit 1 ⇒ gt, else lt; set that flag; →DONE.
  - MSB with is_signed=1: sense is inverted (A bit 1 ⇒ lt).
  - bits equal and idx=0: eq←1; →DONE.
  - bits equal and idx>0: idx←idx−1.
- DONE: done=1 for exactly this cycle, then →IDLE unconditionally.
- Handshakes:
  - start is ignored in RUN and DONE; no queueing.
  - start held high re-triggers on the first IDLE edge after DONE.
- Result hold: gt/lt/eq stay stable from the DONE cycle until the next accepted start clears them. Exactly one flag is high after any completed compare.
- Latency: let i = highest differing bit and n = WIDTH−i (n = WIDTH if A==B).
  - The accept edge is edge 0; RUN occupies edges 1..n; done is high in the cycle after edge n.
  - Minimum n=1 (MSB differs); maximum n=WIDTH.
  - ready is low for n+1 cycles.
- Inputs A/B may change freely after acceptance; only latched copies are used.

Decomposition:
- Shared header holds the state encodings (IDLE=0, RUN=1, DONE=2) and the default WIDTH.
- Sub-module comparator1_slice (combinational) takes a_bit, b_bit and invert. It outputs differ and a_wins.
- The controller instantiates one slice.
- invert = is_signed & (idx==WIDTH−1).

Test Plan:
- Reset, then A=8'h02, B=8'h02, unsigned, start 1 cycle → n=8; done pulse 9 cycles after the accept edge; eq=1, gt=lt=0; ready low for 9 cycles.
- A=8'h14, B=8'h0B unsigned → first difference at bit 4, n=4; gt=1. Then A=8'h0F, B=8'h26 → bit 5, n=3; lt=1. Flags clear on the second accept.
- A=8'h80, B=8'h01: unsigned → gt, n=1. Same operands with is_signed=1 → lt, n=1. A=8'hFF, B=8'hFE signed → gt, n=8.
- Start pulsed during RUN and during DONE → ignored, result unchanged. Start held high continuously → back-to-back compares, each separated by one IDLE edge.
- Assert reset on the 3rd RUN cycle of A=8'h00, B=8'h01 → next cycle ready=1, done never pulses, gt=lt=eq=0. A new start afterwards completes normally with lt, n=8.
- Change A/B every cycle after acceptance of A=8'h01, B=8'h02 → result is lt with n=7, using only the latched values.
